ps2_mouse_rx: RTL and testbench

//   Receive-only PS/2 mouse front end feeding game_console mouse_x/is_mouse_x_neg/mouse_y/is_mouse_y_neg.

---
 rtl/ps2_mouse_rx_pkg.sv | 25 ++
 rtl/ps2_mouse_rx_if.sv | 22 ++
 rtl/ps2_mouse_rx_byte.sv | 123 ++++++++++++
 rtl/ps2_mouse_rx.sv | 113 +++++++++++
 tb/tb_ps2_mouse_rx.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_mouse_rx_pkg.sv
// rtl/ps2_mouse_rx_pkg.sv - shared types, bit positions and delta conversion for the PS/2 mouse receiver
package ps2_mouse_rx_pkg;

   localparam int FRAME_BITS   = 11;
   localparam int DATA_BITS    = FRAME_BITS - 3;
   localparam int B0_ALIGN_BIT = 3;
   localparam int B0_XS_BIT    = 4;
   localparam int B0_YS_BIT    = 5;
   localparam int B0_XO_BIT    = 6;
   localparam int B0_YO_BIT    = 7;

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} byte_state_t;
   typedef enum logic [1:0] {B0, B1, B2} pkt_state_t;

   // 9-bit two's-complement delta to {sign, magnitude}; -256 and overflow clamp to 255
   function automatic logic [8:0] to_sign_mag(input logic s, input logic ovf, input logic [7:0] b);
      logic [8:0] d;
      logic [8:0] mag;
      d   = {s, b};
      mag = s ? (~d + 9'd1) : d;
      if (ovf || mag[8]) return {s, 8'hFF};
      return {s, mag[7:0]};
   endfunction

endpackage

// File: rtl/ps2_mouse_rx_if.sv
// rtl/ps2_mouse_rx_if.sv - PS/2 pad inputs and decoded mouse packet outputs
interface ps2_mouse_rx_if;
   logic       ps2_clk_i;
   logic       ps2_data_i;
   logic [7:0] mouse_x;
   logic       is_mouse_x_neg;
   logic [7:0] mouse_y;
   logic       is_mouse_y_neg;
   logic [2:0] mouse_btn;
   logic       mouse_valid;
   logic       rx_err;

   modport slave (
      input  ps2_clk_i, ps2_data_i,
      output mouse_x, is_mouse_x_neg, mouse_y, is_mouse_y_neg, mouse_btn, mouse_valid, rx_err
   );

   modport master (
      output ps2_clk_i, ps2_data_i,
      input  mouse_x, is_mouse_x_neg, mouse_y, is_mouse_y_neg, mouse_btn, mouse_valid, rx_err
   );
endinterface

// File: rtl/ps2_mouse_rx_byte.sv
// rtl/ps2_mouse_rx_byte.sv - pad synchronisers, ps2_clk deglitch filter, 11-bit frame FSM and inactivity timeout
module ps2_mouse_rx_byte
   import ps2_mouse_rx_pkg::*;
#(
   parameter int CLK_HZ     = 36_000_000,
   parameter int TIMEOUT_US = 2000,
   parameter int FILTER_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   input  logic       i_pkt_busy,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_byte_err
);

   localparam int TO_LIMIT = (CLK_HZ / 1_000_000) * TIMEOUT_US;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);
   localparam int FW       = $clog2(FILTER_LEN);

   logic [1:0]            r_clk_sync, r_dat_sync;
   logic                  r_clk_filt;
   logic [FW-1:0]         r_filt_cnt;
   logic [FILTER_LEN-1:0] r_dat_pipe;
   logic                  r_fall, r_fall_dat;
   byte_state_t           r_state, w_state_nxt;
   logic [2:0]            r_bit_cnt;
   logic [7:0]            r_shift;
   logic                  r_par;
   logic [TO_W-1:0]       r_to_cnt;
   logic                  r_byte_valid, r_byte_err;
   logic                  w_accept, w_busy, w_timeout, w_done, w_perr;

   assign w_accept  = (r_clk_sync[1] != r_clk_filt) && (r_filt_cnt == FW'(FILTER_LEN - 1));
   assign w_busy    = (r_state != IDLE) || i_pkt_busy;
   assign w_timeout = w_busy && !r_fall && (r_to_cnt == TO_W'(TO_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_clk_sync <= 2'b11;
         r_dat_sync <= 2'b11;
         r_dat_pipe <= '1;
         r_clk_filt <= 1'b1;
         r_filt_cnt <= '0;
         r_fall     <= 1'b0;
         r_fall_dat <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
         r_dat_sync <= {r_dat_sync[0], i_ps2_data};
         r_dat_pipe <= {r_dat_pipe[FILTER_LEN-2:0], r_dat_sync[1]};
         if (r_clk_sync[1] == r_clk_filt) begin
            r_filt_cnt <= '0;
         end else if (w_accept) begin
            r_clk_filt <= r_clk_sync[1];
            r_filt_cnt <= '0;
         end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
         end
         // data is taken from the same age as the clock level that just got accepted
         r_fall     <= w_accept && r_clk_filt;
         r_fall_dat <= r_dat_pipe[FILTER_LEN-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || r_fall || !w_busy || w_timeout) r_to_cnt <= '0;
      else if (r_to_cnt != TO_W'(TO_LIMIT))      r_to_cnt <= r_to_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_perr      = 1'b0;
      if (w_timeout) begin
         w_state_nxt = IDLE;
      end else if (r_fall) begin
         case (r_state)
            IDLE:    if (!r_fall_dat) w_state_nxt = SHIFT;
            SHIFT:   if (r_bit_cnt == 3'(DATA_BITS - 1)) w_state_nxt = PARITY;
            PARITY:  w_state_nxt = STOP;
            STOP: begin
               w_state_nxt = IDLE;
               if (r_fall_dat && (^{r_shift, r_par})) w_done = 1'b1;
               else                                   w_perr = 1'b1;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_par        <= 1'b0;
         r_byte_valid <= 1'b0;
         r_byte_err   <= 1'b0;
      end else begin
         r_byte_valid <= w_done;
         r_byte_err   <= w_perr || w_timeout;
         if (r_fall) begin
            if (r_state == IDLE) r_bit_cnt <= '0;
            if (r_state == SHIFT) begin
               r_shift   <= {r_fall_dat, r_shift[7:1]};
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == PARITY) r_par <= r_fall_dat;
         end
      end
   end

   assign o_byte       = r_shift;
   assign o_byte_valid = r_byte_valid;
   assign o_byte_err   = r_byte_err;

endmodule

// File: rtl/ps2_mouse_rx.sv
// rtl/ps2_mouse_rx.sv - PS/2 mouse receiver top: 3-byte packet assembly and sign-magnitude outputs
module ps2_mouse_rx
   import ps2_mouse_rx_pkg::*;
#(
   parameter int CLK_HZ     = 36_000_000,
   parameter int TIMEOUT_US = 2000,
   parameter int FILTER_LEN = 8
) (
   input  logic          clk,
   input  logic          rst,
   ps2_mouse_rx_if.slave bus
);

   logic [7:0] w_byte;
   logic       w_byte_valid, w_byte_err, w_align_err;
   logic [8:0] w_sm_x, w_sm_y;
   pkt_state_t r_pkt_state, w_pkt_nxt;
   logic [2:0] r_btn;
   logic       r_xs, r_ys, r_xo, r_yo;
   logic [7:0] r_xlo;
   logic [7:0] r_mouse_x, r_mouse_y;
   logic       r_x_neg, r_y_neg;
   logic [2:0] r_mouse_btn;
   logic       r_valid, r_err;

   ps2_mouse_rx_byte #(
      .CLK_HZ     (CLK_HZ),
      .TIMEOUT_US (TIMEOUT_US),
      .FILTER_LEN (FILTER_LEN)
   ) u_byte (
      .clk          (clk),
      .rst          (rst),
      .i_ps2_clk    (bus.ps2_clk_i),
      .i_ps2_data   (bus.ps2_data_i),
      .i_pkt_busy   (r_pkt_state != B0),
      .o_byte       (w_byte),
      .o_byte_valid (w_byte_valid),
      .o_byte_err   (w_byte_err)
   );

   assign w_sm_x = to_sign_mag(r_xs, r_xo, r_xlo);
   assign w_sm_y = to_sign_mag(r_ys, r_yo, w_byte);

   always_ff @(posedge clk) begin
      if (rst) r_pkt_state <= B0;
      else     r_pkt_state <= w_pkt_nxt;
   end

   always_comb begin
      w_pkt_nxt   = r_pkt_state;
      w_align_err = 1'b0;
      if (w_byte_err) begin
         w_pkt_nxt = B0;
      end else if (w_byte_valid) begin
         case (r_pkt_state)
            B0: begin
               if (w_byte[B0_ALIGN_BIT]) w_pkt_nxt   = B1;
               else                      w_align_err = 1'b1;
            end
            B1:      w_pkt_nxt = B2;
            B2:      w_pkt_nxt = B0;
            default: w_pkt_nxt = B0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn       <= '0;
         r_xs        <= 1'b0;
         r_ys        <= 1'b0;
         r_xo        <= 1'b0;
         r_yo        <= 1'b0;
         r_xlo       <= '0;
         r_mouse_x   <= '0;
         r_mouse_y   <= '0;
         r_x_neg     <= 1'b0;
         r_y_neg     <= 1'b0;
         r_mouse_btn <= '0;
         r_valid     <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err   <= w_byte_err || w_align_err;
         r_valid <= 1'b0;
         if (w_byte_valid && !w_byte_err) begin
            if (r_pkt_state == B0 && w_byte[B0_ALIGN_BIT]) begin
               r_btn <= w_byte[2:0];
               r_xs  <= w_byte[B0_XS_BIT];
               r_ys  <= w_byte[B0_YS_BIT];
               r_xo  <= w_byte[B0_XO_BIT];
               r_yo  <= w_byte[B0_YO_BIT];
            end
            if (r_pkt_state == B1) r_xlo <= w_byte;
            // Y conversion uses the live byte so the whole packet lands together with the strobe
            if (r_pkt_state == B2) begin
               r_valid     <= 1'b1;
               r_mouse_btn <= r_btn;
               {r_x_neg, r_mouse_x} <= w_sm_x;
               {r_y_neg, r_mouse_y} <= w_sm_y;
            end
         end
      end
   end

   assign bus.mouse_x        = r_mouse_x;
   assign bus.is_mouse_x_neg = r_x_neg;
   assign bus.mouse_y        = r_mouse_y;
   assign bus.is_mouse_y_neg = r_y_neg;
   assign bus.mouse_btn      = r_mouse_btn;
   assign bus.mouse_valid    = r_valid;
   assign bus.rx_err         = r_err;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb/tb_ps2_mouse_rx.sv - scoreboard bench driving PS/2 frames at 80 us per bit with a 1 MHz clock
module tb_ps2_mouse_rx;

   localparam int CLK_HZ   = 1_000_000;
   localparam int CLK_NS   = 1000;
   localparam int HALF_BIT = 40;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #(CLK_NS / 2) clk = ~clk;

   ps2_mouse_rx_if bus ();

   ps2_mouse_rx #(
      .CLK_HZ     (CLK_HZ),
      .TIMEOUT_US (2000),
      .FILTER_LEN (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int exp_err = 0;
   int act_err = 0;
   logic [20:0] exp_q[$];

   // expected packet: {btn, x_neg, |x|, y_neg, |y|}
   function automatic logic [20:0] model(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      int dx, dy, mx, my;
      dx = b0[4] ? int'(b1) - 256 : int'(b1);
      dy = b0[5] ? int'(b2) - 256 : int'(b2);
      mx = (dx < 0) ? -dx : dx;
      my = (dy < 0) ? -dy : dy;
      if (b0[6] || mx > 255) mx = 255;
      if (b0[7] || my > 255) my = 255;
      return {b0[2:0], b0[4], 8'(mx), b0[5], 8'(my)};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rx_err) act_err++;
         if (bus.mouse_valid) begin
            logic [20:0] act;
            act = {bus.mouse_btn, bus.is_mouse_x_neg, bus.mouse_x, bus.is_mouse_y_neg, bus.mouse_y};
            checks++;
            if (bus.rx_err) begin
               errors++;
               $display("FAIL valid_err_excl: rx_err=1 with mouse_valid, required 0");
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_valid: got packet %h, required no packet", act);
            end else begin
               logic [20:0] exp;
               exp = exp_q.pop_front();
               if (act !== exp) begin
                  errors++;
                  $display("FAIL packet: got btn=%b xn=%b x=%0d yn=%b y=%0d, required btn=%b xn=%b x=%0d yn=%b y=%0d",
                           act[20:18], act[17], act[16:9], act[8], act[7:0],
                           exp[20:18], exp[17], exp[16:9], exp[8], exp[7:0]);
               end
            end
         end
      end
   end

   task automatic drive_bits(input logic [10:0] f, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         bus.ps2_data_i = f[i];
         repeat (HALF_BIT / 2) @(posedge clk);
         bus.ps2_clk_i = 1'b0;
         repeat (HALF_BIT) @(posedge clk);
         bus.ps2_clk_i = 1'b1;
         repeat (HALF_BIT / 2) @(posedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_par);
      drive_bits({1'b1, (~^b) ^ bad_par, b, 1'b0}, 11);
      bus.ps2_data_i = 1'b1;
      repeat (HALF_BIT) @(posedge clk);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d packets outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input string name);
      exp_q.push_back(model(b0, b1, b2));
      send_byte(b0, 1'b0);
      send_byte(b1, 1'b0);
      send_byte(b2, 1'b0);
      wait_drain(name);
   endtask

   task automatic check_errs(input string name);
      repeat (20) @(posedge clk);
      checks++;
      if (act_err != exp_err) begin
         errors++;
         $display("FAIL %s_rx_err_count: got %0d, required %0d", name, act_err, exp_err);
         act_err = exp_err;
      end
   endtask

   task automatic check_zero(input string name);
      logic [22:0] v;
      v = {bus.mouse_btn, bus.is_mouse_x_neg, bus.mouse_x, bus.is_mouse_y_neg, bus.mouse_y,
           bus.mouse_valid, bus.rx_err};
      checks++;
      if (v !== 23'd0) begin
         errors++;
         $display("FAIL %s: outputs %h, required 0", name, v);
      end
   endtask

   initial begin
      #(150_000_000);
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r0, r1, r2;
      bus.ps2_clk_i  = 1'b1;
      bus.ps2_data_i = 1'b1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      check_zero("reset_state");

      send_pkt(8'h08, 8'h05, 8'h03, "basic");
      check_errs("basic");

      send_pkt(8'h39, 8'hFB, 8'hFF, "negative");
      send_pkt(8'h18, 8'h00, 8'h00, "minus256");
      check_errs("negative");

      send_pkt(8'h48, 8'h10, 8'h00, "x_overflow");
      send_pkt(8'h88, 8'h00, 8'h00, "y_overflow");
      check_errs("overflow");

      send_byte(8'h08, 1'b0);
      send_byte(8'h05, 1'b1);
      exp_err++;
      check_errs("bad_parity");
      send_pkt(8'h08, 8'h01, 8'h01, "after_parity");

      send_byte(8'h05, 1'b0);
      exp_err++;
      check_errs("misaligned");
      send_byte(8'h08, 1'b0);
      send_byte(8'h02, 1'b0);
      repeat (2500) @(posedge clk);
      exp_err++;
      check_errs("timeout");
      send_pkt(8'h08, 8'h07, 8'h00, "after_timeout");

      send_pkt(8'h0F, 8'h21, 8'h42, "pre_reset");
      send_byte(8'h08, 1'b0);
      drive_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 5);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check_zero("mid_packet_reset");
      bus.ps2_data_i = 1'b1;
      repeat (200) @(posedge clk);

      bus.ps2_data_i = 1'b0;
      repeat (10) @(posedge clk);
      bus.ps2_clk_i = 1'b0;
      repeat (4) @(posedge clk);
      bus.ps2_clk_i = 1'b1;
      repeat (10) @(posedge clk);
      bus.ps2_data_i = 1'b1;
      repeat (100) @(posedge clk);
      check_errs("glitch");
      send_pkt(8'h08, 8'h03, 8'h02, "after_reset");
      check_errs("after_reset");

      for (int i = 0; i < 6; i++) begin
         r0 = 8'($urandom) | 8'h08;
         r1 = 8'($urandom);
         r2 = 8'($urandom);
         send_pkt(r0, r1, r2, "random");
      end
      check_errs("random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
